idu_stage: RTL and testbench
============================

# idu_stage

Pipelined, parametrised RV32 instruction decode stage. Accepts fetched instructions over a valid/ready handshake and produces one registered, fully decoded bundle per instruction: register indices, immediate, ALU op and control bits. The decode logic itself is purely combinational. This block adds output registering, backpressure, flush, and a run/halt state machine that stops issue after EBREAK/ECALL/illegal. It sits between the IFU and the EXU and supports both RV32E and RV32I register files.

## Interface
Parameters:
- `REG_ADDR_W`, default 4: register index width. 4 selects RV32E (16 regs); 5 selects RV32I.
- `XLEN`, default 32: datapath width of `pc` and `imm`.

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: the IFU presents `in_inst`/`in_pc`.
- `in_ready` out 1: the stage accepts this cycle.
- `in_inst` in 32: raw instruction.
- `in_pc` in XLEN: instruction address.
- `flush` in 1: kills the held bundle and clears HALT.
- `out_valid` out 1: the decoded bundle is valid.
- `out_ready` in 1: the EXU consumes the bundle.
- `out_pc` out XLEN: registered `in_pc`.
- `rs1_addr`, `rs2_addr`, `rd_addr` out REG_ADDR_W each: register indices.
- `imm` out XLEN: sign-extended immediate.
- `alu_op` out `ALU_OP_W` (5): ALU operation code.
- `ctrl` out `CTRL_W`: packed control bits `{mem_read, mem_write, reg_write, alu_src, mem_to_reg, branch, jump, ecall, ebreak, illegal}`.
- `mem_size` out 3: funct3 for loads and stores, 0 otherwise.
- `halted` out 1: the state machine is in HALT.

## Operation
- Fields:
  - opcode = inst[6:0], funct3 = inst[14:12], funct7 = inst[31:25].
  - Register indices are inst[19:15], inst[24:20] and inst[11:7], truncated to REG_ADDR_W bits.
- Immediates, all sign-extended to XLEN:
  - I-type: inst[31:20].
  - S-type: {inst[31:25], inst[11:7]}.
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - U-type: {inst[31:12], 12'b0}.
- alu_op codes:
  - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - BEQ A, BNE B, BLT C, BGE D, BLTU E, BGEU F.
  - PASSB 10 (LUI).
- Op selection:
  - SUB and SRA are selected by funct7 = 0100000.
  - SRAI is selected by inst[30].
  - Load, store, JAL, JALR and AUIPC use ADD.
- Control bits by opcode:
  - R-type: reg_write.
  - I-ALU: reg_write, alu_src.
  - Load: reg_write, alu_src, mem_read, mem_to_reg.
  - Store: alu_src, mem_write.
  - Branch: branch.
  - JAL: reg_write, jump.
  - JALR: reg_write, jump, alu_src.
  - LUI and AUIPC: reg_write, alu_src.
  - SYSTEM, funct3 = 0: inst[31:20] = 0 gives ecall; inst[31:20] = 1 gives ebreak.
- Unlisted opcodes decode to all-zero controls.
- State machine:
  - RUN → HALT when a bundle with ecall, ebreak or illegal is loaded into the output register.
  - HALT → RUN on `flush`.
  - `rst` → RUN.

## Timing
- Latency: the bundle appears exactly 1 cycle after the accepting edge (`in_valid && in_ready`).
- `in_ready` = RUN && !flush && (!out_valid || out_ready). This gives full throughput with no bubbles under continuous `out_ready`.
- `out_valid` and the bundle stay stable while `out_valid && !out_ready`. Input fields must not leak through.
- Flush:
  - `flush` clears `out_valid` next cycle.
  - It overrides a simultaneous accept (the instruction is dropped) and a simultaneous consume.
- HALT:
  - The trapping bundle is still delivered and consumable.
  - No further accepts occur until `flush`.
- Reset values: `out_valid` = 0, `halted` = 0, and every bundle output (`out_pc`, indices, `imm`, `alu_op`, `ctrl`, `mem_size`) = 0.
- Reset mid-transfer discards the held bundle.
- `in_ready` is 0 during the reset cycle.

## Configuration
- `IDU_ILLEGAL_CHECK_EN` defined: `illegal` is set when any of the following holds:
  - the opcode is unlisted;
  - R-type funct7 is not in {0000000, 0100000}, or funct7 = 0100000 with funct3 not in {000, 101};
  - Branch funct3 is 010 or 011;
  - any used register index has bits above REG_ADDR_W set.
  
  An illegal bundle causes HALT.
- `IDU_ILLEGAL_CHECK_EN` undefined:
  - `illegal` is tied to 0.
  - Unknown opcodes pass as NOPs (all-zero controls).
  - Indices are silently truncated.

## Structure
- Package `idu_pkg`: `ALU_OP_W`, the alu_op localparams, opcode localparams, `CTRL_W` and the ctrl bit positions, and a packed `idu_bundle_t`.
- Sub-module `idu_dec`: purely combinational inst → bundle plus illegal flag.
- `idu_stage`: the handshake, the output register and the RUN/HALT state machine.

## Test plan
- `addi x1,x0,5` (0x00500093), sinks ready:
  - Next cycle `out_valid` = 1, `rd` = 1, `rs1` = 0, `imm` = 5, `alu_op` = 0, reg_write = 1, alu_src = 1.
- `beq x1,x2,-4` (0xFE208EE3):
  - `imm` = 0xFFFFFFFC, `alu_op` = 0xA, branch = 1, `rs1` = 1, `rs2` = 2.
- Backpressure: hold `out_ready` = 0 with 3 instructions queued at the IFU.
  - `in_ready` = 0 after the first accept and the bundle stays stable.
  - After releasing `out_ready`, all 3 emerge in order with no duplicates.
- `ebreak` (0x00100073):
  - ebreak = 1 and `halted` = 1 the next cycle, with `in_ready` = 0 from then on.
  - Pulse `flush`: `halted` = 0, `out_valid` = 0, and accepts resume.
- `REG_ADDR_W` = 4, `add x16,x0,x0` (0x00000833):
  - With the macro: illegal = 1 and HALT.
  - Without it: `rd_addr` = 0 and no HALT.
- Corner cases:
  - `flush` asserted in the same cycle as an accept: `out_valid` = 0 next cycle and the instruction never appears.
  - `rst` asserted mid-stream: all outputs are 0 next cycle.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared decode constants, control-bit positions and the opcode-independent bundle payload.
// Used by idu_dec and idu_stage (optional IDU_ILLEGAL_CHECK_EN lives in idu_dec).
package idu_pkg;

  localparam int unsigned ALU_OP_W = 5;
  localparam int unsigned CTRL_W   = 10;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 5'h00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 5'h01;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 5'h02;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 5'h03;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 5'h04;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 5'h05;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 5'h06;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 5'h07;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 5'h08;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 5'h09;
  localparam logic [ALU_OP_W-1:0] ALU_BEQ   = 5'h0A;
  localparam logic [ALU_OP_W-1:0] ALU_BNE   = 5'h0B;
  localparam logic [ALU_OP_W-1:0] ALU_BLT   = 5'h0C;
  localparam logic [ALU_OP_W-1:0] ALU_BGE   = 5'h0D;
  localparam logic [ALU_OP_W-1:0] ALU_BLTU  = 5'h0E;
  localparam logic [ALU_OP_W-1:0] ALU_BGEU  = 5'h0F;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 5'h10;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ctrl = {mem_read, mem_write, reg_write, alu_src, mem_to_reg, branch, jump, ecall, ebreak, illegal}
  localparam int unsigned CTRL_ILLEGAL    = 0;
  localparam int unsigned CTRL_EBREAK     = 1;
  localparam int unsigned CTRL_ECALL      = 2;
  localparam int unsigned CTRL_JUMP       = 3;
  localparam int unsigned CTRL_BRANCH     = 4;
  localparam int unsigned CTRL_MEM_TO_REG = 5;
  localparam int unsigned CTRL_ALU_SRC    = 6;
  localparam int unsigned CTRL_REG_WRITE  = 7;
  localparam int unsigned CTRL_MEM_WRITE  = 8;
  localparam int unsigned CTRL_MEM_READ   = 9;

  // Width-independent part of a decoded bundle; indices and imm are sized by the stage parameters.
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [CTRL_W-1:0]   ctrl;
    logic [2:0]          mem_size;
  } idu_bundle_t;

  function automatic logic [ALU_OP_W-1:0] alu_arith(input logic [2:0] f3,
                                                    input logic       alt_sub,
                                                    input logic       alt_sra);
    logic [ALU_OP_W-1:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt_sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt_sra ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/idu_dec.sv
// Purely combinational RV32 decoder: instruction word -> indices, immediate, bundle, trap flag.
// Define IDU_ILLEGAL_CHECK_EN to flag illegal encodings; otherwise illegal is tied low.
module idu_dec
  import idu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic [31:0]           inst_i,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]       imm_o,
  output idu_bundle_t           bundle_o,
  output logic                  trap_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm32;
  logic        illegal;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  assign rs1_o = inst_i[15 +: REG_ADDR_W];
  assign rs2_o = inst_i[20 +: REG_ADDR_W];
  assign rd_o  = inst_i[7 +: REG_ADDR_W];
  assign imm_o = XLEN'($signed(imm32));

  always_comb begin
    imm32    = '0;
    bundle_o = '0;
    case (opcode)
      OPC_R: begin
        bundle_o.alu_op = alu_arith(funct3, funct7 == 7'b0100000, funct7 == 7'b0100000);
        bundle_o.ctrl[CTRL_REG_WRITE] = 1'b1;
      end
      OPC_IMM: begin
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        bundle_o.alu_op = alu_arith(funct3, 1'b0, inst_i[30]);
        bundle_o.ctrl[CTRL_REG_WRITE] = 1'b1;
        bundle_o.ctrl[CTRL_ALU_SRC]   = 1'b1;
      end
      OPC_LOAD: begin
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        bundle_o.mem_size = funct3;
        bundle_o.ctrl[CTRL_REG_WRITE]  = 1'b1;
        bundle_o.ctrl[CTRL_ALU_SRC]    = 1'b1;
        bundle_o.ctrl[CTRL_MEM_READ]   = 1'b1;
        bundle_o.ctrl[CTRL_MEM_TO_REG] = 1'b1;
      end
      OPC_STORE: begin
        imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        bundle_o.mem_size = funct3;
        bundle_o.ctrl[CTRL_ALU_SRC]   = 1'b1;
        bundle_o.ctrl[CTRL_MEM_WRITE] = 1'b1;
      end
      OPC_BRANCH: begin
        imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        case (funct3)
          3'b000:  bundle_o.alu_op = ALU_BEQ;
          3'b001:  bundle_o.alu_op = ALU_BNE;
          3'b100:  bundle_o.alu_op = ALU_BLT;
          3'b101:  bundle_o.alu_op = ALU_BGE;
          3'b110:  bundle_o.alu_op = ALU_BLTU;
          3'b111:  bundle_o.alu_op = ALU_BGEU;
          default: bundle_o.alu_op = ALU_ADD;
        endcase
        bundle_o.ctrl[CTRL_BRANCH] = 1'b1;
      end
      OPC_JAL: begin
        imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        bundle_o.ctrl[CTRL_REG_WRITE] = 1'b1;
        bundle_o.ctrl[CTRL_JUMP]      = 1'b1;
      end
      OPC_JALR: begin
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        bundle_o.ctrl[CTRL_REG_WRITE] = 1'b1;
        bundle_o.ctrl[CTRL_JUMP]      = 1'b1;
        bundle_o.ctrl[CTRL_ALU_SRC]   = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {inst_i[31:12], 12'b0};
        bundle_o.alu_op = (opcode == OPC_LUI) ? ALU_PASSB : ALU_ADD;
        bundle_o.ctrl[CTRL_REG_WRITE] = 1'b1;
        bundle_o.ctrl[CTRL_ALU_SRC]   = 1'b1;
      end
      OPC_SYSTEM: begin
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        bundle_o.ctrl[CTRL_ECALL]  = (funct3 == 3'b000) && (inst_i[31:20] == 12'd0);
        bundle_o.ctrl[CTRL_EBREAK] = (funct3 == 3'b000) && (inst_i[31:20] == 12'd1);
      end
      default: ;
    endcase
    bundle_o.ctrl[CTRL_ILLEGAL] = illegal;
  end

`ifdef IDU_ILLEGAL_CHECK_EN
  logic hi_rs1, hi_rs2, hi_rd;

  // Index bits above REG_ADDR_W address registers this core does not have.
  assign hi_rs1 = (inst_i[19:15] >> REG_ADDR_W) != 5'd0;
  assign hi_rs2 = (inst_i[24:20] >> REG_ADDR_W) != 5'd0;
  assign hi_rd  = (inst_i[11:7]  >> REG_ADDR_W) != 5'd0;

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OPC_R:
        illegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000))
               || ((funct7 == 7'b0100000) && !((funct3 == 3'b000) || (funct3 == 3'b101)))
               || hi_rs1 || hi_rs2 || hi_rd;
      OPC_IMM, OPC_LOAD, OPC_JALR:  illegal = hi_rs1 || hi_rd;
      OPC_STORE:                    illegal = hi_rs1 || hi_rs2;
      OPC_BRANCH:                   illegal = (funct3[2:1] == 2'b01) || hi_rs1 || hi_rs2;
      OPC_JAL, OPC_LUI, OPC_AUIPC:  illegal = hi_rd;
      OPC_SYSTEM:                   illegal = 1'b0;
      default:                      illegal = 1'b1;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

  assign trap_o = bundle_o.ctrl[CTRL_ECALL] | bundle_o.ctrl[CTRL_EBREAK] | bundle_o.ctrl[CTRL_ILLEGAL];

endmodule

// File: rtl/idu_stage.sv
// RV32 decode stage: valid/ready handshake, registered decoded bundle, RUN/HALT issue control.
// Illegal-encoding trapping is enabled by IDU_ILLEGAL_CHECK_EN (see idu_dec).
module idu_stage
  import idu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       imm,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic [CTRL_W-1:0]     ctrl,
  output logic [2:0]            mem_size,
  output logic                  halted
);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       pc_q, pc_d, imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  idu_bundle_t           bun_q, bun_d;

  logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]       dec_imm;
  idu_bundle_t           dec_bun;
  logic                  dec_trap;
  logic                  accept;

  idu_dec #(.REG_ADDR_W(REG_ADDR_W), .XLEN(XLEN)) u_dec (
    .inst_i   (in_inst),
    .rs1_o    (dec_rs1),
    .rs2_o    (dec_rs2),
    .rd_o     (dec_rd),
    .imm_o    (dec_imm),
    .bundle_o (dec_bun),
    .trap_o   (dec_trap)
  );

  assign in_ready = !rst && (state_q == ST_RUN) && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next state: flush beats accept and consume; a trapping bundle still loads before HALT.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    bun_d   = bun_q;
    if (flush) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      imm_d   = dec_imm;
      rs1_d   = dec_rs1;
      rs2_d   = dec_rs2;
      rd_d    = dec_rd;
      bun_d   = dec_bun;
      if (dec_trap) state_d = ST_HALT;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      bun_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      bun_q   <= bun_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign rs1_addr  = rs1_q;
  assign rs2_addr  = rs2_q;
  assign rd_addr   = rd_q;
  assign imm       = imm_q;
  assign alu_op    = bun_q.alu_op;
  assign ctrl      = bun_q.ctrl;
  assign mem_size  = bun_q.mem_size;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: directed scenarios plus random traffic against a cycle-level reference model.
// Honors IDU_ILLEGAL_CHECK_EN the same way the design does.
module tb_idu_stage;

  localparam int unsigned RW = 4;
  localparam int unsigned XL = 32;

  localparam logic [31:0] I_ADDI   = 32'h00500093;
  localparam logic [31:0] I_BEQ    = 32'hFE208EE3;
  localparam logic [31:0] I_EBREAK = 32'h00100073;
  localparam logic [31:0] I_ADD16  = 32'h00000833;

  logic          clk, rst, in_valid, in_ready, flush, out_valid, out_ready, halted;
  logic [31:0]   in_inst;
  logic [XL-1:0] in_pc, out_pc, imm;
  logic [RW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [4:0]    alu_op;
  logic [9:0]    ctrl;
  logic [2:0]    mem_size;

  idu_stage #(.REG_ADDR_W(RW), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .imm(imm), .alu_op(alu_op), .ctrl(ctrl), .mem_size(mem_size), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [9:0]  ctrl;
    logic [2:0]  msz;
    bit          trap;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          m_valid, m_halt, last_acc, mon_en;
  logic [31:0] m_pc;
  exp_t        m_b;
  logic [31:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set tables, in integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] inst);
    exp_t e;
    int x, op, f3, f7, r1, r2, rdf, alu;
    int immI, immS, immB, immJ, immU;
    int ar[8];
    bit mr, mw, rw, asrc, m2r, br, jp, ec, eb, il, bad, u1, u2, ud;
    ar = '{0, 2, 3, 4, 5, 6, 8, 9};
    x   = int'(inst);
    op  = x & 127;
    f3  = (x >> 12) & 7;
    f7  = (x >> 25) & 127;
    r1  = (x >> 15) & 31;
    r2  = (x >> 20) & 31;
    rdf = (x >> 7) & 31;
    immI = x >>> 20;
    immS = ((x >>> 25) << 5) | rdf;
    immB = ((x >>> 31) << 12) | (((x >> 7) & 1) << 11) | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
    immJ = ((x >>> 31) << 20) | (((x >> 12) & 255) << 12) | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
    immU = x & int'(32'hFFFFF000);
    {mr, mw, rw, asrc, m2r, br, jp, ec, eb, il, bad, u1, u2, ud} = '0;
    alu = 0;
    e.imm = 32'd0;
    e.msz = 3'd0;
    case (op)
      51: begin
        rw = 1; u1 = 1; u2 = 1; ud = 1;
        alu = ar[f3];
        if (f7 == 32 && f3 == 0) alu = 1;
        if (f7 == 32 && f3 == 5) alu = 7;
        bad = (f7 != 0 && f7 != 32) || (f7 == 32 && f3 != 0 && f3 != 5);
      end
      19: begin
        rw = 1; asrc = 1; u1 = 1; ud = 1; e.imm = 32'(immI);
        alu = ar[f3];
        if (f3 == 5 && ((x >> 30) & 1) == 1) alu = 7;
      end
      3:   begin rw = 1; asrc = 1; mr = 1; m2r = 1; u1 = 1; ud = 1; e.imm = 32'(immI); e.msz = 3'(f3); end
      35:  begin asrc = 1; mw = 1; u1 = 1; u2 = 1; e.imm = 32'(immS); e.msz = 3'(f3); end
      99: begin
        br = 1; u1 = 1; u2 = 1; e.imm = 32'(immB);
        alu = (f3 < 2) ? 10 + f3 : ((f3 >= 4) ? 8 + f3 : 0);
        bad = (f3 == 2 || f3 == 3);
      end
      111: begin rw = 1; jp = 1; ud = 1; e.imm = 32'(immJ); end
      103: begin rw = 1; jp = 1; asrc = 1; u1 = 1; ud = 1; e.imm = 32'(immI); end
      55:  begin rw = 1; asrc = 1; ud = 1; alu = 16; e.imm = 32'(immU); end
      23:  begin rw = 1; asrc = 1; ud = 1; e.imm = 32'(immU); end
      115: begin
        e.imm = 32'(immI);
        ec = (f3 == 0 && immI == 0);
        eb = (f3 == 0 && immI == 1);
      end
      default: bad = 1;
    endcase
`ifdef IDU_ILLEGAL_CHECK_EN
    il = bad || (u1 && r1 >= (1 << RW)) || (u2 && r2 >= (1 << RW)) || (ud && rdf >= (1 << RW));
`else
    il = 0;
`endif
    e.rs1  = r1 % (1 << RW);
    e.rs2  = r2 % (1 << RW);
    e.rd   = rdf % (1 << RW);
    e.alu  = 5'(alu);
    e.ctrl = {mr, mw, rw, asrc, m2r, br, jp, ec, eb, il};
    e.trap = ec || eb || il;
    return e;
  endfunction

  // One clock: called at a negedge, checks registered outputs, drives inputs, advances the model.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic fl, input logic ordy, input logic r);
    bit er;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("halted", 32'(halted), 32'(m_halt));
    if (m_valid) begin
      check("out_pc", out_pc, m_pc);
      check("rs1", 32'(rs1_addr), 32'(m_b.rs1));
      check("rs2", 32'(rs2_addr), 32'(m_b.rs2));
      check("rd", 32'(rd_addr), 32'(m_b.rd));
      check("imm", imm, m_b.imm);
      check("alu_op", 32'(alu_op), 32'(m_b.alu));
      check("ctrl", 32'(ctrl), 32'(m_b.ctrl));
      check("mem_size", 32'(mem_size), 32'(m_b.msz));
    end
    if (mon_en && ordy && out_valid === 1'b1) got_q.push_back(out_pc);
    in_valid = v; in_inst = inst; in_pc = pc; flush = fl; out_ready = ordy; rst = r;
    #1;
    er = !r && !m_halt && !fl && (!m_valid || ordy);
    check("in_ready", 32'(in_ready), 32'(er));
    last_acc = v && er;
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_halt = 0;
    end else if (fl) begin
      m_valid = 0; m_halt = 0;
    end else if (last_acc) begin
      m_b = ref_decode(inst); m_pc = pc; m_valid = 1;
      if (m_b.trap) m_halt = 1;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[10];
    logic [31:0] w;
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    k = $urandom_range(0, 99);
    w = $urandom;
    if (k < 2) return I_EBREAK;
    if (k < 4) return 32'h00000073;
    if (k < 7) return w;
    w[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 9) != 0) w = w & ~32'h01080800;
    if (w[6:0] == 7'h33 && $urandom_range(0, 7) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  initial begin
    logic [31:0] src_q[$], spc_q[$], exp_pc[3];
    logic [9:0]  c_snap;

    m_valid = 0; m_halt = 0; m_pc = 0; last_acc = 0; mon_en = 0;
    m_b = '{default: 0};
    in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; out_ready = 1; rst = 1;
    @(negedge clk);
    step(1, I_ADDI, 32'h10, 0, 1, 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_pc", out_pc, 0);
    check("rst_imm", imm, 0);
    check("rst_ctrl", 32'(ctrl), 0);
    check("rst_alu", 32'(alu_op), 0);

    step(1, I_ADDI, 32'h100, 0, 1, 0);
    check("addi_valid", 32'(out_valid), 1);
    check("addi_rd", 32'(rd_addr), 1);
    check("addi_rs1", 32'(rs1_addr), 0);
    check("addi_imm", imm, 5);
    check("addi_alu", 32'(alu_op), 0);
    check("addi_ctrl", 32'(ctrl), 32'h0C0);

    step(1, I_BEQ, 32'h104, 0, 1, 0);
    check("beq_imm", imm, 32'hFFFFFFFC);
    check("beq_alu", 32'(alu_op), 32'hA);
    check("beq_ctrl", 32'(ctrl), 32'h010);
    check("beq_rs1", 32'(rs1_addr), 1);
    check("beq_rs2", 32'(rs2_addr), 2);
    step(0, 0, 0, 0, 1, 0);

    // Backpressure: three queued instructions, sink stalled for a while.
    src_q = '{32'h00100113, 32'h002081B3, 32'h40208233};
    spc_q = '{32'h200, 32'h204, 32'h208};
    exp_pc = '{32'h200, 32'h204, 32'h208};
    got_q.delete();
    mon_en = 1;
    for (int c = 0; c < 40; c++) begin
      if (src_q.size() > 0) step(1, src_q[0], spc_q[0], 0, c >= 6, 0);
      else step(0, 0, 0, 0, c >= 6, 0);
      if (last_acc) begin
        void'(src_q.pop_front());
        void'(spc_q.pop_front());
      end
      if (c == 4) begin
        check("bp_hold_ready", 32'(in_ready), 0);
        check("bp_hold_pc", out_pc, 32'h200);
      end
    end
    mon_en = 0;
    check("bp_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("bp_order%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, exp_pc[i]);

    // EBREAK halts issue until flush.
    step(1, I_EBREAK, 32'h300, 0, 1, 0);
    check("ebreak_ctrl", 32'(ctrl), 32'h002);
    check("ebreak_halted", 32'(halted), 1);
    step(1, I_ADDI, 32'h304, 0, 1, 0);
    check("halt_in_ready", 32'(in_ready), 0);
    step(0, 0, 0, 1, 1, 0);
    check("flush_halted", 32'(halted), 0);
    check("flush_valid", 32'(out_valid), 0);
    step(1, I_ADDI, 32'h308, 0, 1, 0);
    check("resume_valid", 32'(out_valid), 1);
    check("resume_pc", out_pc, 32'h308);

    // Register index beyond RV32E.
    step(1, I_ADD16, 32'h400, 0, 1, 0);
    c_snap = ctrl;
`ifdef IDU_ILLEGAL_CHECK_EN
    check("x16_illegal", 32'(c_snap[0]), 1);
    check("x16_halted", 32'(halted), 1);
    step(0, 0, 0, 1, 1, 0);
`else
    check("x16_illegal", 32'(c_snap[0]), 0);
    check("x16_rd", 32'(rd_addr), 0);
    check("x16_halted", 32'(halted), 0);
`endif

    // Flush with a simultaneous accept drops the instruction.
    step(1, I_ADDI, 32'h500, 1, 1, 0);
    check("flushacc_valid", 32'(out_valid), 0);
    step(0, 0, 0, 0, 1, 0);

    // Reset mid-stream.
    step(1, I_BEQ, 32'h600, 0, 0, 0);
    step(1, I_ADDI, 32'h604, 0, 0, 1);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_pc", out_pc, 0);
    check("midrst_rs1", 32'(rs1_addr), 0);
    check("midrst_rs2", 32'(rs2_addr), 0);
    check("midrst_imm", imm, 0);
    check("midrst_alu", 32'(alu_op), 0);
    check("midrst_ctrl", 32'(ctrl), 0);

    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFFFFFC,
           $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    step(0, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
